// File: rtl/hi_lo_muldiv_if.sv
// hi_lo_muldiv_if: bundle between the control decoder / register file and the
// HI/LO multiply-divide unit.
//   funct       - instruction funct field
//   write_hi    - MTHI, or MULT/MULTU/DIV/DIVU start strobe
//   write_lo    - MTLO strobe
//   read_hi_lo  - MFHI/MFLO strobe
//   rs_data     - rs operand (multiplicand / dividend / MTHI / MTLO source)
//   rt_data     - rt operand (multiplier / divisor)
//   hi_lo_out   - MFHI/MFLO result toward the write-data mux
//   busy        - operation in flight, pipeline stalls
//   hi_out      - current HI register (debug)
//   lo_out      - current LO register (debug)
interface hi_lo_muldiv_if #(parameter int WIDTH = 32);
  logic [5:0]       funct;
  logic             write_hi;
  logic             write_lo;
  logic             read_hi_lo;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] hi_lo_out;
  logic             busy;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output funct, write_hi, write_lo, read_hi_lo, rs_data, rt_data,
    input  hi_lo_out, busy, hi_out, lo_out
  );

  modport slave (
    input  funct, write_hi, write_lo, read_hi_lo, rs_data, rt_data,
    output hi_lo_out, busy, hi_out, lo_out
  );
endinterface

// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit: owns HI/LO and runs MULT/MULTU/DIV/DIVU iteratively,
// one operand bit per cycle, followed by a single sign-fix cycle.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - hi_lo_muldiv_if.slave (decoder strobes, operands, results, busy)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepts MTHI/MTLO/start; HI/LO readable
// MUL   | shift-add, one multiplier bit per cycle (WIDTH cycles)
// DIV   | restoring division, one quotient bit per cycle (WIDTH cycles)
// FIX   | sign correction / divide-by-zero result, writes HI and LO
module hi_lo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  hi_lo_muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d;          // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {upper: partial product / remainder, lower: multiplier / quotient}
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
  logic [CW-1:0]      counter_q, counter_d;
  logic               neg_q_q, neg_q_d;  // product / quotient sign
  logic               neg_r_q, neg_r_d;  // remainder sign
  logic               dz_q, dz_d;
  logic               is_div_q, is_div_d;
  logic               busy_q, busy_d;

  logic               start_op, op_signed;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum, rem_shift, trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic               last;

  always_comb begin
    start_op  = bus.write_hi && (bus.funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    op_signed = ~bus.funct[0];
    rs_mag    = (op_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    rt_mag    = (op_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
    last      = (counter_q == CW'(WIDTH - 1));

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift right keeping the carry.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: the shifted remainder needs one extra bit so the
    // trial subtraction's sign is observable.
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    trial     = rem_shift - {1'b0, a_q};
    div_next  = {(trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~trial[WIDTH]};

    prod_fix  = neg_q_q ? -acc_q : acc_q;

    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    acc_d     = acc_q;
    rs_raw_d  = rs_raw_q;
    counter_d = counter_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dz_d      = dz_q;
    is_div_d  = is_div_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (start_op) begin
          is_div_d  = bus.funct[1];
          neg_q_d   = op_signed && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
          neg_r_d   = op_signed && bus.rs_data[WIDTH-1];
          dz_d      = (bus.rt_data == '0);
          rs_raw_d  = bus.rs_data;
          counter_d = '0;
          busy_d    = 1'b1;
          if (bus.funct[1]) begin
            a_d     = rt_mag;
            acc_d   = {{WIDTH{1'b0}}, rs_mag};
            state_d = DIV;
          end else begin
            a_d     = rs_mag;
            acc_d   = {{WIDTH{1'b0}}, rt_mag};
            state_d = MUL;
          end
        end else begin
          if (bus.write_hi && bus.funct == 6'h11) hi_d = bus.rs_data;
          if (bus.write_lo && bus.funct == 6'h13) lo_d = bus.rs_data;
        end
      end
      MUL, DIV: begin
        acc_d     = (state_q == MUL) ? mul_next : div_next;
        counter_d = counter_q + CW'(1);
        if (last) state_d = FIX;
      end
      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      rs_raw_q  <= '0;
      counter_q <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      rs_raw_q  <= rs_raw_d;
      counter_q <= counter_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dz_q      <= dz_d;
      is_div_q  <= is_div_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    bus.hi_lo_out = '0;
    if (bus.read_hi_lo && !busy_q) begin
      if (bus.funct == 6'h10)      bus.hi_lo_out = hi_q;
      else if (bus.funct == 6'h12) bus.hi_lo_out = lo_q;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
module tb_hi_lo_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  hi_lo_muldiv_if #(.WIDTH(32)) bus ();

  hi_lo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.funct      = 6'h00;
    bus.write_hi   = 1'b0;
    bus.write_lo   = 1'b0;
    bus.read_hi_lo = 1'b0;
  endtask

  task automatic issue(input logic [5:0] f, input logic wh, input logic wl,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.funct    = f;
    bus.write_hi = wh;
    bus.write_lo = wl;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    step();
    idle_inputs();
  endtask

  task automatic read_reg(input string tag, input logic [5:0] f, input logic [31:0] exp);
    bus.funct      = f;
    bus.read_hi_lo = 1'b1;
    #1;
    chk(tag, {32'h0, bus.hi_lo_out}, {32'h0, exp});
    idle_inputs();
  endtask

  // Start an op, scramble operands, count busy cycles, then check HI/LO.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(f, 1'b1, 1'b0, rs, rt);
    bus.rs_data = 32'h1357_9BDF;
    bus.rt_data = 32'h2468_ACE0;
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, {32'h0, bus.hi_out}, {32'h0, exp_hi});
    chk({tag, "_lo"}, {32'h0, bus.lo_out}, {32'h0, exp_lo});
  endtask

  initial begin
    int n;
    idle_inputs();
    bus.rs_data = '0;
    bus.rt_data = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_hi", {32'h0, bus.hi_out}, 64'h0);
    chk("reset_lo", {32'h0, bus.lo_out}, 64'h0);
    chk("reset_busy", {63'h0, bus.busy}, 64'h0);
    read_reg("reset_mfhi", 6'h10, 32'h0);

    issue(6'h11, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
    issue(6'h13, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
    read_reg("mfhi", 6'h10, 32'hDEAD_BEEF);
    read_reg("mflo", 6'h12, 32'h1234_5678);
    chk("mt_busy", {63'h0, bus.busy}, 64'h0);
    // Strobe with an unrelated funct must leave HI alone.
    issue(6'h20, 1'b1, 1'b0, 32'h0BAD_0BAD, 32'h0);
    chk("bad_funct_hi", {32'h0, bus.hi_out}, 64'hDEAD_BEEF);

    run_op("mult_neg3x7", 6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100_7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_by0", 6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_neg_by0", 6'h1A, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_min_neg1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    // Back-to-back start right after the previous op finished.
    run_op("mult_b2b", 6'h18, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6);

    // Ignore-while-busy: MTHI at cycle 10, DIVU at cycle 11.
    issue(6'h11, 1'b1, 1'b0, 32'h0000_0077, 32'h0);
    issue(6'h19, 1'b1, 1'b0, 32'd3, 32'd4);
    n = 1;
    repeat (9) begin step(); n++; end
    issue(6'h11, 1'b1, 1'b0, 32'hAAAA_5555, 32'h0);
    n++;
    chk("busy_mthi_ignored", {32'h0, bus.hi_out}, 64'h77);
    issue(6'h1B, 1'b1, 1'b0, 32'd100, 32'd7);
    n++;
    chk("busy_still_high", {63'h0, bus.busy}, 64'h1);
    while (bus.busy && n < 100) begin step(); n++; end
    chk("busy_ign_cycles", 64'(n), 64'd34);
    chk("busy_ign_hi", {32'h0, bus.hi_out}, 64'h0);
    chk("busy_ign_lo", {32'h0, bus.lo_out}, 64'd12);
    step();
    chk("busy_no_queue", {63'h0, bus.busy}, 64'h0);
    chk("busy_no_queue_lo", {32'h0, bus.lo_out}, 64'd12);

    // Reset mid-operation.
    issue(6'h13, 1'b0, 1'b1, 32'h55, 32'h0);
    chk("mtlo_55", {32'h0, bus.lo_out}, 64'h55);
    issue(6'h1B, 1'b1, 1'b0, 32'd100, 32'd7);
    repeat (14) step();
    chk("pre_reset_busy", {63'h0, bus.busy}, 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset_busy", {63'h0, bus.busy}, 64'h0);
    chk("mid_reset_hi", {32'h0, bus.hi_out}, 64'h0);
    chk("mid_reset_lo", {32'h0, bus.lo_out}, 64'h0);
    repeat (25) step();
    chk("mid_reset_no_late_write", {32'h0, bus.lo_out}, 64'h0);
    run_op("mult_after_reset", 6'h18, 32'd2, 32'd3, 32'h0, 32'd6);
    read_reg("final_mflo", 6'h12, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
